term_cmd_decoder: RTL

//  Upstream stage of the text controller in the serial terminal. Buffers bytes from the

---
 rtl/term_cmd_decoder_pkg.sv | 43 ++++
 rtl/term_cmd_decoder_if.sv | 23 ++
 rtl/term_cmd_decoder_sync_fifo.sv | 51 +++++
 rtl/term_cmd_decoder.sv | 102 ++++++++++
 4 files changed

// File: rtl/term_cmd_decoder_pkg.sv
// Shared constants, FSM state codes and the byte classifier for the terminal
// command decoder.
package term_cmd_decoder_pkg;

    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;
    localparam logic [7:0] ASCII_C     = 8'h63;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_DEC  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_PUT,
        CMD_CLEAR
    } cmd_e;

    typedef struct packed {
        cmd_e cmd;
        logic esc_next;
    } decode_t;

    // Maps (escape pending, byte) to the command to emit and the next escape flag.
    function automatic decode_t classify(input logic esc, input logic [7:0] b);
        decode_t d;
        d.cmd      = CMD_NONE;
        d.esc_next = 1'b0;
        if (!esc) begin
            if (b >= ASCII_SPACE && b <= ASCII_TILDE) d.cmd = CMD_PUT;
            else if (b == ASCII_FF)                   d.cmd = CMD_CLEAR;
            else if (b == ASCII_ESC)                  d.esc_next = 1'b1;
        end else begin
            if (b == ASCII_C)        d.cmd = CMD_CLEAR;
            else if (b == ASCII_ESC) d.esc_next = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/term_cmd_decoder_if.sv
// Byte input, busy feedback and command outputs of the terminal command decoder.
interface term_cmd_decoder_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]       i_rx_byte;
    logic             i_rx_valid;
    logic             i_busy;
    logic             o_putchar;
    logic [7:0]       o_char;
    logic             o_clearhome;
    logic             o_overflow;
    logic [FIFO_AW:0] o_fifo_level;

    modport master (
        output i_rx_byte, i_rx_valid, i_busy,
        input  o_putchar, o_char, o_clearhome, o_overflow, o_fifo_level
    );

    modport slave (
        input  i_rx_byte, i_rx_valid, i_busy,
        output o_putchar, o_char, o_clearhome, o_overflow, o_fifo_level
    );
endinterface

// File: rtl/term_cmd_decoder_sync_fifo.sv
// Single-clock FIFO with registered read data; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_rd_data,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          pop_ok;
    logic          push_ok;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_level = wr_ptr - rd_ptr;
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_rd_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) begin
                rd_ptr    <= rd_ptr + 1'b1;
                o_rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/term_cmd_decoder.sv
// Buffers received bytes and decodes them into paced putchar/clearhome pulses
// for the text controller.
module term_cmd_decoder
    import term_cmd_decoder_pkg::*;
#(
    parameter int FIFO_AW   = 4,
    parameter int CLR_GUARD = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    term_cmd_decoder_if.slave    bus
);
    localparam logic [3:0] GUARD_INIT = 4'(CLR_GUARD);

    logic [1:0]       state;
    logic             esc;
    logic [3:0]       guard_cnt;
    logic             putchar_q;
    logic             clear_q;
    logic [7:0]       char_q;
    logic             overflow_q;

    logic             pop;
    logic             drop;
    logic [7:0]       rd_data;
    logic [FIFO_AW:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    decode_t          decode;

    sync_fifo #(
        .AW (FIFO_AW),
        .DW (8)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (bus.i_rx_valid),
        .i_wr_data (bus.i_rx_byte),
        .i_pop     (pop),
        .o_rd_data (rd_data),
        .o_level   (fifo_level),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    // Popping only while the controller is idle keeps commands out of a running scroll.
    assign pop    = (state == ST_IDLE) && !fifo_empty && !bus.i_busy;
    assign drop   = bus.i_rx_valid && fifo_full && !pop;
    assign decode = classify(esc, rd_data);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            esc        <= 1'b0;
            guard_cnt  <= '0;
            putchar_q  <= 1'b0;
            clear_q    <= 1'b0;
            char_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make each pulse last exactly one cycle;
            // a later assignment in the same block wins.
            putchar_q <= 1'b0;
            clear_q   <= 1'b0;
            if (drop) overflow_q <= 1'b1;

            case (state)
                ST_IDLE: if (pop) state <= ST_RD;
                ST_RD:   state <= ST_DEC;
                ST_DEC: begin
                    esc   <= decode.esc_next;
                    state <= ST_IDLE;
                    case (decode.cmd)
                        CMD_PUT: begin
                            putchar_q <= 1'b1;
                            char_q    <= rd_data;
                        end
                        CMD_CLEAR: begin
                            clear_q   <= 1'b1;
                            guard_cnt <= GUARD_INIT;
                            state     <= ST_HOLD;
                        end
                        default: ;
                    endcase
                end
                ST_HOLD: begin
                    // Give the controller time to raise busy before trusting it.
                    if (guard_cnt != 4'd0)  guard_cnt <= guard_cnt - 1'b1;
                    else if (!bus.i_busy)   state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_putchar    = putchar_q;
    assign bus.o_clearhome  = clear_q;
    assign bus.o_char       = char_q;
    assign bus.o_overflow   = overflow_q;
    assign bus.o_fifo_level = fifo_level;

endmodule
